// File: rtl/aq_memcpy_wr_burst.sv
// aq_memcpy_wr_burst: drains the memcpy data FIFO into AXI4 INCR write bursts, one burst outstanding.
// Define AQ_MEMCPY_WR_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module aq_memcpy_wr_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [ADDR_WIDTH-1:0]   DST_ADRS,
    input  logic [LEN_WIDTH-1:0]    WORD_COUNT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic                    FIFO_RD_ENA,
    input  logic [DATA_WIDTH-1:0]   FIFO_RD_DATA,
    input  logic                    FIFO_RD_EMPTY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY
);
    localparam int SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, awaddr_q, awaddr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [7:0]              awlen_q, awlen_d, beat_q, beat_d;
    logic                    err_q, err_d;
    logic [12:0]             len;
    logic [8:0]              burst;
    logic                    wvalid;
`ifdef AQ_MEMCPY_WR_4K_SPLIT_EN
    logic [12:0]             page_words;
`endif

    // Candidate length for the next burst, evaluated from the running address/remaining count.
    always_comb begin
        len = (rem_q < LEN_WIDTH'(MAX_BURST)) ? 13'(rem_q) : 13'(MAX_BURST);
`ifdef AQ_MEMCPY_WR_4K_SPLIT_EN
        page_words = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
        len = (page_words < len) ? page_words : len;
`endif
    end

    assign burst  = {1'b0, awlen_q} + 9'd1;
    assign wvalid = (state_q == S_W) & ~FIFO_RD_EMPTY;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        awaddr_d = awaddr_q;
        rem_d    = rem_q;
        awlen_d  = awlen_q;
        beat_d   = beat_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (START) begin
                addr_d  = DST_ADRS;
                rem_d   = WORD_COUNT;
                err_d   = 1'b0;
                state_d = (WORD_COUNT == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                awaddr_d = addr_q;
                awlen_d  = 8'(len - 13'd1);
                state_d  = S_AW;
            end
            S_AW: if (M_AXI_AWREADY) begin
                addr_d  = addr_q + (ADDR_WIDTH'(burst) << SIZE);
                rem_d   = rem_q - LEN_WIDTH'(burst);
                beat_d  = 8'd0;
                state_d = S_W;
            end
            S_W: if (wvalid && M_AXI_WREADY) begin
                beat_d  = (beat_q == awlen_q) ? 8'd0 : beat_q + 8'd1;
                state_d = (beat_q == awlen_q) ? S_B : S_W;
            end
            S_B: if (M_AXI_BVALID) begin
                err_d   = err_q | (M_AXI_BRESP != 2'b00);
                state_d = (rem_q == '0) ? S_DONE : S_CALC;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            awaddr_q <= '0;
            rem_q    <= '0;
            awlen_q  <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            awaddr_q <= awaddr_d;
            rem_q    <= rem_d;
            awlen_q  <= awlen_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
        end
    end

    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_DONE);
    assign ERROR         = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = (state_q == S_AW);
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_WDATA   = FIFO_RD_DATA;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wvalid & (beat_q == awlen_q);
    assign FIFO_RD_ENA   = wvalid & M_AXI_WREADY;
    assign M_AXI_BREADY  = (state_q == S_B);
endmodule
